// File: rtl/rca_8_pkg.sv
// Shared constants for the registered ripple-carry adder.
package rca_8_pkg;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/rca_8_if.sv
// Operand/result bundle for one rca_8 instance. The master drives the operands
// and the slave returns the registered sum and carry.
interface rca_8_if #(
  parameter int data_width = rca_8_pkg::DEFAULT_WIDTH
);

  logic [data_width-1:0] a;
  logic [data_width-1:0] b;
  logic                  cin;
  logic [data_width-1:0] sum;
  logic                  cout;

  modport master (output a, b, cin, input sum, cout);
  modport slave  (input a, b, cin, output sum, cout);

endinterface

// File: rtl/rca_8_full_adder.sv
// Single-bit combinational full adder, one link of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/rca_8.sv
// Ripple-carry adder with registered {COUT,SUM}; one-cycle latency, one result
// per cycle, asynchronous active-high clear of the output registers.
module rca_8
  import rca_8_pkg::*;
#(
  parameter int data_width = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] A,
  input  logic [data_width-1:0] B,
  input  logic                  CIN,
  output logic [data_width-1:0] SUM,
  output logic                  COUT
);

  logic [data_width:0]   carry;
  logic [data_width-1:0] sum_next;
  logic [data_width-1:0] sum_reg;
  logic                  cout_reg;

  assign carry[0] = CIN;

  generate
    for (genvar gi = 0; gi < data_width; gi++) begin : g_bit
      full_adder u_fa (
        .a    (A[gi]),
        .b    (B[gi]),
        .cin  (carry[gi]),
        .s    (sum_next[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else begin
      sum_reg  <= sum_next;
      cout_reg <= carry[data_width];
    end
  end

  assign SUM  = sum_reg;
  assign COUT = cout_reg;

endmodule

// File: tb/tb_rca_8.sv
// Self-checking bench for rca_8 at the default width and at data_width=16.
module tb_rca_8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rca_8_if #(8)  bus8 ();
  rca_8_if #(16) bus16 ();

  rca_8 dut8 (
    .clk  (clk),
    .rst  (rst),
    .A    (bus8.a),
    .B    (bus8.b),
    .CIN  (bus8.cin),
    .SUM  (bus8.sum),
    .COUT (bus8.cout)
  );

  rca_8 #(16) dut16 (
    .clk  (clk),
    .rst  (rst),
    .A    (bus16.a),
    .B    (bus16.b),
    .CIN  (bus16.cin),
    .SUM  (bus16.sum),
    .COUT (bus16.cout)
  );

  // Reference: plain integer addition of the operands
  function automatic int model_add(input int a, input int b, input int cin);
    return a + b + cin;
  endfunction

  function automatic int got8();
    return int'({bus8.cout, bus8.sum});
  endfunction

  function automatic int got16();
    return int'({bus16.cout, bus16.sum});
  endfunction

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus8.a   = a;
    bus8.b   = b;
    bus8.cin = cin;
  endtask

  task automatic test_reset();
    bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    drive8(8'hAA, 8'h55, 1'b1);
    #1 rst = 1'b1;
    #1;
    total++;
    if (got8() !== 0) begin
      bad++;
      $display("FAIL reset_immediate: got %0h expected 0", got8());
    end else $display("txn reset_immediate: {cout,sum}=%0h", got8());
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (got8() !== 0) begin
        bad++;
        $display("FAIL reset_hold%0d: got %0h expected 0", i, got8());
      end else $display("txn reset_hold%0d: {cout,sum}=%0h", i, got8());
    end
    // First edge after release captures the operands already present
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (got8() !== model_add(8'hAA, 8'h55, 1)) begin
      bad++;
      $display("FAIL reset_release: got %0h expected %0h", got8(), model_add(8'hAA, 8'h55, 1));
    end else $display("txn reset_release: {cout,sum}=%0h", got8());
  endtask

  task automatic test_mid_reset();
    @(negedge clk) drive8(8'hF0, 8'h0F, 1'b1);
    @(posedge clk); #1;
    total++;
    if (got8() !== model_add(8'hF0, 8'h0F, 1)) begin
      bad++;
      $display("FAIL mid_reset_pre: got %0h expected %0h", got8(), model_add(8'hF0, 8'h0F, 1));
    end else $display("txn mid_reset_pre: {cout,sum}=%0h", got8());
    @(negedge clk); #1 rst = 1'b1;
    #1;
    total++;
    if (got8() !== 0) begin
      bad++;
      $display("FAIL mid_reset_clear: got %0h expected 0", got8());
    end else $display("txn mid_reset_clear: {cout,sum}=%0h", got8());
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] av [4] = '{8'h00, 8'hFF, 8'hFF, 8'h80};
    logic [7:0] bv [4] = '{8'h00, 8'h01, 8'hFF, 8'h80};
    logic       cv [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) drive8(av[i], bv[i], cv[i]);
      @(posedge clk); #1;
      total++;
      if (got8() !== model_add(int'(av[i]), int'(bv[i]), int'(cv[i]))) begin
        bad++;
        $display("FAIL directed%0d: got %0h expected %0h", i, got8(),
                 model_add(int'(av[i]), int'(bv[i]), int'(cv[i])));
      end else $display("txn directed%0d: %0h+%0h+%0h -> %0h", i, av[i], bv[i], cv[i], got8());
    end
  endtask

  task automatic test_latency();
    @(negedge clk) drive8(8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    total++;
    if (got8() !== 'h46) begin
      bad++;
      $display("FAIL latency_edge: got %0h expected 46", got8());
    end else $display("txn latency_edge: {cout,sum}=%0h", got8());
    #2 drive8(8'hFF, 8'hFF, 1'b1);
    #1;
    total++;
    if (got8() !== 'h46) begin
      bad++;
      $display("FAIL latency_hold: got %0h expected 46", got8());
    end else $display("txn latency_hold: {cout,sum}=%0h", got8());
    @(posedge clk); #1;
    total++;
    if (got8() !== 'h1FF) begin
      bad++;
      $display("FAIL latency_next: got %0h expected 1ff", got8());
    end else $display("txn latency_next: {cout,sum}=%0h", got8());
  endtask

  task automatic test_back_to_back();
    int expected = 0;
    logic [7:0] a, b;
    logic       c;
    for (int i = 0; i <= 1000; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (got8() !== expected) begin
          bad++;
          $display("FAIL random%0d: got %0h expected %0h", i, got8(), expected);
        end
      end
      if (i < 1000) begin
        a = 8'($urandom);
        b = 8'($urandom);
        c = 1'($urandom);
        drive8(a, b, c);
        expected = model_add(int'(a), int'(b), int'(c));
      end
    end
    $display("txn random: 1000 vectors checked");
  endtask

  task automatic test_param16();
    logic [15:0] a, b;
    logic        c;
    @(negedge clk) begin
      bus16.a = 16'hFFFF; bus16.b = 16'h0000; bus16.cin = 1'b1;
    end
    @(posedge clk); #1;
    total++;
    if (bus16.sum !== 16'h0000 || bus16.cout !== 1'b1) begin
      bad++;
      $display("FAIL width16_wrap: got sum=%0h cout=%0b expected sum=0 cout=1", bus16.sum, bus16.cout);
    end else $display("txn width16_wrap: sum=%0h cout=%0b", bus16.sum, bus16.cout);
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      @(negedge clk) begin
        bus16.a = a; bus16.b = b; bus16.cin = c;
      end
      @(posedge clk); #1;
      total++;
      if (got16() !== model_add(int'(a), int'(b), int'(c))) begin
        bad++;
        $display("FAIL width16_rand%0d: got %0h expected %0h", i, got16(),
                 model_add(int'(a), int'(b), int'(c)));
      end else $display("txn width16_rand%0d: %0h+%0h+%0h -> %0h", i, a, b, c, got16());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_latency();
    test_mid_reset();
    test_back_to_back();
    test_param16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
